// File: rtl/shift_left_seq_if.sv
//==============================================================================
// Module      : shift_left_seq_if
// Description : Start/busy/done handshake bundle for the sequential left shifter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface shift_left_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] input_a;
  logic [SHW-1:0]   shamt;
  logic             rot;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shift_result;

  modport master (
    output start, input_a, shamt, rot,
    input  busy, done, shift_result
  );

  modport slave (
    input  start, input_a, shamt, rot,
    output busy, done, shift_result
  );
endinterface

`default_nettype wire

// File: rtl/shift_left_seq.sv
//==============================================================================
// Module      : shift_left_seq
// Description : Multi-cycle logical shift-left, one bit per clock (sll/sllv).
//               Define SHIFT_LEFT_SEQ_ROTATE_EN to enable rotate-left via rot.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_left_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  wire logic       clk,
  input  wire logic       reset,
  shift_left_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [SHW-1:0] C_COUNT_ONE = SHW'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_count;
  logic             r_rot;
  logic [WIDTH-1:0] r_result;
  logic             w_fill;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_last   = (r_state == ST_SHIFT) && (r_count == '0);

`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
  assign w_fill = r_rot & r_data[WIDTH-1];
`else
  // Rotate disabled: the latched mode bit is masked so fill stays zero.
  assign w_fill = r_rot & 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_count == '0) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_SHIFT: w_busy = 1'b1;
      ST_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Operand, count and mode capture plus the per-cycle shift step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_count <= '0;
      r_rot   <= 1'b0;
    end else if (w_accept) begin
      r_data  <= bus.input_a;
      r_count <= bus.shamt;
      r_rot   <= bus.rot;
    end else if ((r_state == ST_SHIFT) && (r_count != '0)) begin
      r_data  <= {r_data[WIDTH-2:0], w_fill};
      r_count <= r_count - C_COUNT_ONE;
    end
  end

  // Result only moves on entry to DONE so it holds across idle periods.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else if (w_last) begin
      r_result <= r_data;
    end
  end

  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.shift_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_shift_left_seq.sv
//==============================================================================
// Module      : tb_shift_left_seq
// Description : Directed scoreboard bench for shift_left_seq.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_shift_left_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  shift_left_seq_if #(.WIDTH(32), .SHW(5)) sif ();

  shift_left_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  function automatic logic [31:0] model(input logic [31:0] a, input int sh, input logic rt);
    logic [31:0] r;
    r = a << sh;
    if (ROT_EN && rt && (sh != 0)) r = r | (a >> (32 - sh));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; inject>0 pulses a competing start on that busy cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input int sh,
                       input logic rt, input int inject);
    int cyc;
    int nbusy;
    logic [31:0] expv;
    sif.start   = 1'b1;
    sif.input_a = a;
    sif.shamt   = 5'(sh);
    sif.rot     = rt;
    exp_q.push_back(model(a, sh, rt));
    step();
    sif.start = 1'b0;
    cyc   = 0;
    nbusy = 0;
    while (!sif.done && cyc < 40) begin
      if (sif.busy) nbusy++;
      sif.input_a = $urandom;
      sif.shamt   = 5'($urandom_range(31, 0));
      sif.rot     = ~rt;
      if (inject > 0 && cyc == inject) begin
        sif.start   = 1'b1;
        sif.input_a = 32'h5;
        sif.shamt   = 5'd2;
      end
      step();
      sif.start = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(sh + 1));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(sh + 1));
    check({tag, "_busy_at_done"}, 32'(sif.busy), 32'd0);
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check({tag, "_result"}, sif.shift_result, expv);
    step();
    check({tag, "_done_pulse"}, 32'(sif.done), 32'd0);
    check({tag, "_result_hold"}, sif.shift_result, expv);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    sif.start   = 1'b0;
    sif.input_a = '0;
    sif.shamt   = '0;
    sif.rot     = 1'b0;
    step();
    step();
    check("reset_busy", 32'(sif.busy), 32'd0);
    check("reset_done", 32'(sif.done), 32'd0);
    check("reset_result", sif.shift_result, 32'd0);
    reset = 1'b0;
    step();

    do_op("basic", 32'h00000001, 4, 1'b0, 0);
    check("basic_value", sif.shift_result, 32'h00000010);
    do_op("zero", 32'hDEADBEEF, 0, 1'b0, 0);
    do_op("max", 32'hFFFFFFFF, 31, 1'b0, 0);
    check("max_value", sif.shift_result, 32'h80000000);
    do_op("rot1", 32'h80000001, 1, 1'b1, 0);
    check("rot1_value", sif.shift_result, ROT_EN ? 32'h00000003 : 32'h00000002);
    do_op("rot12", 32'h12345678, 12, 1'b1, 0);
    do_op("norot", 32'h80000001, 1, 1'b0, 0);

    // Competing start during SHIFT must be dropped; next op follows immediately.
    do_op("ignore", 32'h00000001, 8, 1'b0, 3);
    check("ignore_value", sif.shift_result, 32'h00000100);
    do_op("b2b", 32'h00000005, 2, 1'b0, 0);
    check("b2b_value", sif.shift_result, 32'h00000014);

    // Abort mid-shift with reset.
    sif.start   = 1'b1;
    sif.input_a = 32'h00000001;
    sif.shamt   = 5'd20;
    sif.rot     = 1'b0;
    step();
    sif.start = 1'b0;
    repeat (4) step();
    check("pre_reset_busy", 32'(sif.busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(sif.busy), 32'd0);
    check("abort_done", 32'(sif.done), 32'd0);
    check("abort_result", sif.shift_result, 32'd0);
    step();
    do_op("after_reset", 32'h0000000F, 3, 1'b0, 0);
    check("after_reset_value", sif.shift_result, 32'h00000078);

    for (int i = 0; i < 6; i++) begin
      do_op("rand", $urandom, int'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), 0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
